// File: rtl/stack_seq_ctrl.sv
// stack_seq_ctrl: multi-cycle PUSH/POP sequencer.
// Walks the latched register list lowest-first (extra register last), issuing
// one word transfer per register over a req/ack port, then writes back SP.
module stack_seq_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [7:0]        r_list,
  input  logic              extra_en,
  input  logic [3:0]        extra_reg,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [3:0]        rf_addr,
  output logic              rf_we,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_we
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_UPD  = 2'd3;

  localparam logic [3:0] OP_PUSH = 4'd0;
  localparam logic [3:0] OP_POP  = 4'd1;

  logic [1:0]        state;
  logic              op_push;
  logic [7:0]        rem;       // low registers still to transfer
  logic              ext_pend;  // extra register still to transfer
  logic [3:0]        ext_reg;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] sp_new;

  logic [3:0]        cnt;
  logic [ADDR_W-1:0] span;
  logic [2:0]        low_idx;
  logic [7:0]        rem_next;
  logic              last;
  logic [3:0]        cur_reg;

  // Transfer count, stack span and next-register selection
  always_comb begin
    cnt = {3'd0, ext_pend};
    for (int i = 0; i < 8; i++) cnt = cnt + {3'd0, rem[i]};
    span = ADDR_W'(WORD_BYTES) * ADDR_W'(cnt);
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (rem[i]) low_idx = 3'(i);
    rem_next = rem & (rem - 8'd1);
    last     = (rem == 8'd0) || (rem_next == 8'd0 && !ext_pend);
    cur_reg  = (rem != 8'd0) ? {1'b0, low_idx} : ext_reg;
  end

  // Sequencer state, latched operands and address walk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_push  <= 1'b0;
      rem      <= 8'd0;
      ext_pend <= 1'b0;
      ext_reg  <= 4'd0;
      sp       <= '0;
      addr     <= '0;
      sp_new   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (opcode == OP_PUSH || opcode == OP_POP)) begin
            op_push  <= (opcode == OP_PUSH);
            rem      <= r_list;
            ext_pend <= extra_en;
            ext_reg  <= extra_reg;
            sp       <= sp_in;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          // Full-descending stack: both ops start at the lowest slot
          addr   <= op_push ? sp - span : sp;
          sp_new <= op_push ? sp - span : sp + span;
          state  <= (cnt != 4'd0) ? S_XFER : S_UPD;
        end
        S_XFER: begin
          if (mem_ack) begin
            addr <= addr + ADDR_W'(WORD_BYTES);
            if (rem != 8'd0) rem <= rem_next;
            else             ext_pend <= 1'b0;
            if (last) state <= S_UPD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign mem_req  = (state == S_XFER);
  assign mem_we   = mem_req & op_push;
  assign mem_addr = addr;
  assign rf_addr  = mem_req ? cur_reg : 4'd0;
  assign rf_we    = mem_req & mem_ack & ~mem_we;
  assign done     = (state == S_UPD);
  assign sp_we    = (state == S_UPD);
  assign sp_out   = sp_new;

endmodule
